// File: rtl/uart_cmd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl_pkg
//   Shared UART definitions: uart_regs register offsets, host command byte
//   field positions, default ACK/NAK codes and the command sequencer state
//   type.
// -----------------------------------------------------------------------------
package uart_cmd_ctrl_pkg;

    // uart_regs register offsets
    localparam logic [2:0] UART_DOUTL_OFFSET = 3'd0;
    localparam logic [2:0] UART_DOUTH_OFFSET = 3'd1;
    localparam logic [2:0] UART_DINL_OFFSET  = 3'd2;
    localparam logic [2:0] UART_DINH_OFFSET  = 3'd3;

    // Host command byte layout: [7] write flag, [6:3] reserved (zero), [2:0] address
    localparam int unsigned CMD_WR_BIT   = 7;
    localparam int unsigned CMD_RSVD_MSB = 6;
    localparam int unsigned CMD_RSVD_LSB = 3;
    localparam int unsigned CMD_ADDR_MSB = 2;
    localparam int unsigned CMD_ADDR_LSB = 0;

    // Default response codes
    localparam logic [7:0] UART_ACK_DEFAULT = 8'h06;
    localparam logic [7:0] UART_NAK_DEFAULT = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_WR_REQ,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_RESP
    } cmd_state_e;

    // A command is malformed when any reserved bit is set.
    function automatic logic cmd_is_malformed(input logic [7:0] cmd);
        return |cmd[CMD_RSVD_MSB:CMD_RSVD_LSB];
    endfunction

    function automatic logic [2:0] cmd_addr(input logic [7:0] cmd);
        return cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_timeout.sv
// -----------------------------------------------------------------------------
// uart_cmd_timeout
//   Saturating cycle counter bounding how long the sequencer waits for the
//   data byte of a write command.
//
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   clear_i    synchronous clear to zero (has priority over enable_i)
//   enable_i   count one cycle
//   expired_o  counter has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module uart_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned     CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Stops at CNT_MAX so a stalled enable can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
//   Command sequencer between the UART RX/TX FIFOs and uart_regs. Pops a host
//   command byte, issues a single register read or write, and pushes the read
//   data or an ACK/NAK byte back into the TX FIFO.
//
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_rx_fifo_e   RX FIFO empty
//   i_rx_data     RX FIFO head byte (first-word-fall-through)
//   o_rx_rd       RX FIFO pop strobe
//   i_tx_fifo_f   TX FIFO full
//   o_tx_data     byte to TX FIFO
//   o_tx_wr       TX FIFO push strobe
//   o_rwaddr      register address to uart_regs
//   o_write_data  write data to uart_regs
//   o_wr_req      register write strobe
//   o_rd_req      register read strobe
//   i_read_data   uart_regs read data, valid the cycle after o_rd_req
//   o_busy        high whenever a command is in progress
// -----------------------------------------------------------------------------
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  ACK_BYTE       = UART_ACK_DEFAULT,
    parameter logic [7:0]  NAK_BYTE       = UART_NAK_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_fifo_e,
    input  logic [7:0] i_rx_data,
    output logic       o_rx_rd,
    input  logic       i_tx_fifo_f,
    output logic [7:0] o_tx_data,
    output logic       o_tx_wr,
    output logic [2:0] o_rwaddr,
    output logic [7:0] o_write_data,
    output logic       o_wr_req,
    output logic       o_rd_req,
    input  logic [7:0] i_read_data,
    output logic       o_busy
);

    cmd_state_e state_q, state_d;
    logic [2:0] rwaddr_q, rwaddr_d;
    logic [7:0] wdata_q,  wdata_d;
    logic [7:0] resp_q,   resp_d;

    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expired;

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .clear_i   (tmo_clear),
        .enable_i  (tmo_enable),
        .expired_o (tmo_expired)
    );

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            rwaddr_q <= '0;
            wdata_q  <= '0;
            resp_q   <= '0;
        end else begin
            state_q  <= state_d;
            rwaddr_q <= rwaddr_d;
            wdata_q  <= wdata_d;
            resp_q   <= resp_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rwaddr_d   = rwaddr_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;
        tmo_clear  = 1'b0;
        tmo_enable = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!i_rx_fifo_e) begin
                    if (cmd_is_malformed(i_rx_data)) begin
                        // Address register keeps its previous value on NAK.
                        resp_d  = NAK_BYTE;
                        state_d = ST_RESP;
                    end else begin
                        rwaddr_d = cmd_addr(i_rx_data);
                        if (i_rx_data[CMD_WR_BIT]) begin
                            tmo_clear = 1'b1;
                            state_d   = ST_WAIT_DATA;
                        end else begin
                            state_d = ST_RD_REQ;
                        end
                    end
                end
            end

            ST_WAIT_DATA: begin
                // Data present on the expiry cycle still completes the write.
                if (!i_rx_fifo_e) begin
                    wdata_d = i_rx_data;
                    state_d = ST_WR_REQ;
                end else if (tmo_expired) begin
                    resp_d  = NAK_BYTE;
                    state_d = ST_RESP;
                end else begin
                    tmo_enable = 1'b1;
                end
            end

            ST_WR_REQ: begin
                resp_d  = ACK_BYTE;
                state_d = ST_RESP;
            end

            ST_RD_REQ: begin
                state_d = ST_RD_CAP;
            end

            ST_RD_CAP: begin
                resp_d  = i_read_data;
                state_d = ST_RESP;
            end

            ST_RESP: begin
                if (!i_tx_fifo_f) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Strobe outputs
    // -------------------------------------------------------------------------
    always_comb begin
        o_rx_rd  = 1'b0;
        o_tx_wr  = 1'b0;
        o_wr_req = 1'b0;
        o_rd_req = 1'b0;
        o_busy   = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE:      o_rx_rd  = !i_rx_fifo_e;
            ST_WAIT_DATA: o_rx_rd  = !i_rx_fifo_e;
            ST_WR_REQ:    o_wr_req = 1'b1;
            ST_RD_REQ:    o_rd_req = 1'b1;
            ST_RD_CAP:    ;
            ST_RESP:      o_tx_wr  = !i_tx_fifo_f;
            default:      ;
        endcase
    end

    assign o_rwaddr     = rwaddr_q;
    assign o_write_data = wdata_q;
    assign o_tx_data    = resp_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;
    import uart_cmd_ctrl_pkg::*;

    localparam int unsigned TMO = 16;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_rx_fifo_e;
    logic [7:0] i_rx_data;
    logic       o_rx_rd;
    logic       i_tx_fifo_f;
    logic [7:0] o_tx_data;
    logic       o_tx_wr;
    logic [2:0] o_rwaddr;
    logic [7:0] o_write_data;
    logic       o_wr_req;
    logic       o_rd_req;
    logic [7:0] i_read_data;
    logic       o_busy;

    uart_cmd_ctrl #(
        .TIMEOUT_CYCLES (TMO),
        .ACK_BYTE       (8'h06),
        .NAK_BYTE       (8'h15)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_rx_fifo_e  (i_rx_fifo_e),
        .i_rx_data    (i_rx_data),
        .o_rx_rd      (o_rx_rd),
        .i_tx_fifo_f  (i_tx_fifo_f),
        .o_tx_data    (o_tx_data),
        .o_tx_wr      (o_tx_wr),
        .o_rwaddr     (o_rwaddr),
        .o_write_data (o_write_data),
        .o_wr_req     (o_wr_req),
        .o_rd_req     (o_rd_req),
        .i_read_data  (i_read_data),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Environment: RX FIFO contents, captured TX pushes / register strobes,
    // a stand-in register file answering reads, and the reference model.
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    int          txc[$];
    int          popc[$];
    logic [10:0] wrq[$];
    logic [2:0]  rdq[$];
    logic [7:0]  bregs[8];
    logic [7:0]  mregs[8];
    logic [7:0]  expq[$];
    logic [10:0] expwr[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit full_ctl  = 1'b0;
    bit rand_full = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void drive();
        i_rx_fifo_e = (rxq.size() == 0);
        i_rx_data   = (rxq.size() != 0) ? rxq[0] : 8'($urandom);
        i_tx_fifo_f = full_ctl;
    endfunction

    function automatic logic [31:0] tx_at(input int i);
        return (i < int'(txq.size())) ? 32'(txq[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] txc_at(input int i);
        return (i < int'(txc.size())) ? 32'(txc[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] pop_at(input int i);
        return (i < int'(popc.size())) ? 32'(popc[i]) : 32'hFFFF_0000;
    endfunction
    function automatic logic [31:0] wr_at(input int i);
        return (i < int'(wrq.size())) ? 32'(wrq[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] rd_at(input int i);
        return (i < int'(rdq.size())) ? 32'(rdq[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic void clear_logs();
        txq.delete(); txc.delete(); popc.delete(); wrq.delete(); rdq.delete();
        expq.delete(); expwr.delete();
    endfunction

    // One clock: observe at the falling edge, apply FIFO/register effects
    // just after the rising edge.
    task automatic step_cycle();
        logic       s_rx, s_rd, s_wr;
        logic [2:0] s_addr;
        logic [7:0] s_wd;
        @(negedge i_clk);
        check("rx_rd_while_empty", 32'(o_rx_rd & i_rx_fifo_e), 32'd0);
        check("tx_wr_while_full",  32'(o_tx_wr & i_tx_fifo_f), 32'd0);
        check("rd_wr_overlap",     32'(o_rd_req & o_wr_req),   32'd0);
        s_rx = o_rx_rd; s_rd = o_rd_req; s_wr = o_wr_req;
        s_addr = o_rwaddr; s_wd = o_write_data;
        if (o_tx_wr) begin txq.push_back(o_tx_data); txc.push_back(cyc); end
        if (o_rx_rd) popc.push_back(cyc);
        if (o_wr_req) wrq.push_back({o_rwaddr, o_write_data});
        if (o_rd_req) rdq.push_back(o_rwaddr);
        @(posedge i_clk);
        #1;
        if (s_rx && rxq.size() != 0) void'(rxq.pop_front());
        i_read_data = s_rd ? bregs[s_addr] : 8'($urandom);
        if (s_wr) bregs[s_addr] = s_wd;
        if (rand_full) full_ctl = ($urandom_range(0, 2) == 0);
        cyc++;
        drive();
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int k = 0;
        while (int'(txq.size()) < n && k < budget) begin
            step_cycle();
            k++;
        end
        check(tag, 32'(int'(txq.size()) >= n), 32'd1);
    endtask

    task automatic push_rx(input logic [7:0] b);
        rxq.push_back(b);
        drive();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_rd"},  32'(o_rx_rd),      32'd0);
        check({tag, "_tx_wr"},  32'(o_tx_wr),      32'd0);
        check({tag, "_tx_data"},32'(o_tx_data),    32'd0);
        check({tag, "_rwaddr"}, 32'(o_rwaddr),     32'd0);
        check({tag, "_wdata"},  32'(o_write_data), 32'd0);
        check({tag, "_wr_req"}, 32'(o_wr_req),     32'd0);
        check({tag, "_rd_req"}, 32'(o_rd_req),     32'd0);
        check({tag, "_busy"},   32'(o_busy),       32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] cmd;
        logic [2:0] a;
        int         ncmd;
        int         kind;

        i_rst_n     = 1'b0;
        i_read_data = '0;
        for (int i = 0; i < 8; i++) begin
            mregs[i] = 8'($urandom);
            bregs[i] = mregs[i];
        end
        mregs[5] = 8'h5A;
        bregs[5] = 8'h5A;
        drive();
        repeat (3) @(posedge i_clk);
        #1;
        check_outputs_zero("reset");
        i_rst_n = 1'b1;
        repeat (2) step_cycle();

        // Write 0xAA to address 0
        clear_logs();
        push_rx(8'h80); push_rx(8'hAA);
        wait_tx(1, 20, "wr0_tx_wait");
        repeat (2) step_cycle();
        check("wr0_ack",      tx_at(0), 32'h06);
        check("wr0_strobe",   wr_at(0), 32'({3'd0, 8'hAA}));
        check("wr0_nstrobe",  32'(wrq.size()), 32'd1);
        check("wr0_latency",  txc_at(0) - pop_at(1), 32'd2);
        mregs[0] = 8'hAA;

        // Back-to-back writes to DINL / DINH
        clear_logs();
        push_rx(8'h80 | 8'(UART_DINL_OFFSET)); push_rx(8'hFF);
        push_rx(8'h80 | 8'(UART_DINH_OFFSET)); push_rx(8'h07);
        wait_tx(2, 40, "wr23_tx_wait");
        repeat (2) step_cycle();
        check("wr23_ack0",  tx_at(0), 32'h06);
        check("wr23_ack1",  tx_at(1), 32'h06);
        check("wr23_str0",  wr_at(0), 32'({UART_DINL_OFFSET, 8'hFF}));
        check("wr23_str1",  wr_at(1), 32'({UART_DINH_OFFSET, 8'h07}));
        check("wr23_ntx",   32'(txq.size()), 32'd2);
        mregs[2] = 8'hFF;
        mregs[3] = 8'h07;

        // Read address 5
        clear_logs();
        push_rx(8'h05);
        wait_tx(1, 20, "rd5_tx_wait");
        repeat (2) step_cycle();
        check("rd5_data",    tx_at(0), 32'h5A);
        check("rd5_addr",    rd_at(0), 32'd5);
        check("rd5_latency", txc_at(0) - pop_at(0), 32'd3);
        check("rd5_nowr",    32'(wrq.size()), 32'd0);

        // Reserved bits set
        clear_logs();
        push_rx(8'h48);
        wait_tx(1, 20, "rsvd_tx_wait");
        step_cycle();
        check("rsvd_nak",     tx_at(0), 32'h15);
        check("rsvd_nostrb",  32'(wrq.size() + rdq.size()), 32'd0);
        check("rsvd_idle",    32'(o_busy), 32'd0);

        // Write with no data byte: 16 empty WAIT_DATA cycles, then NAK
        clear_logs();
        push_rx(8'h81);
        wait_tx(1, 40, "tmo_tx_wait");
        repeat (2) step_cycle();
        check("tmo_nak",     tx_at(0), 32'h15);
        check("tmo_latency", txc_at(0) - pop_at(0), 32'(TMO + 1));
        check("tmo_nowr",    32'(wrq.size()), 32'd0);
        check("tmo_npop",    32'(popc.size()), 32'd1);

        // Data byte arriving on the last counted cycle still completes
        clear_logs();
        push_rx(8'h81);
        step_cycle();
        repeat (TMO - 1) step_cycle();
        d = 8'($urandom);
        push_rx(d);
        wait_tx(1, 20, "tmoedge_tx_wait");
        repeat (2) step_cycle();
        check("tmoedge_ack",   tx_at(0), 32'h06);
        check("tmoedge_wr",    wr_at(0), 32'({3'd1, d}));
        check("tmoedge_gap",   pop_at(1) - pop_at(0), 32'(TMO));
        check("tmoedge_lat",   txc_at(0) - pop_at(1), 32'd2);
        mregs[1] = d;

        // TX FIFO full holds the response
        clear_logs();
        full_ctl = 1'b1;
        push_rx(8'h03);
        repeat (12) step_cycle();
        check("full_nopush", 32'(txq.size()), 32'd0);
        check("full_busy",   32'(o_busy), 32'd1);
        full_ctl = 1'b0;
        drive();
        wait_tx(1, 10, "full_tx_wait");
        repeat (3) step_cycle();
        check("full_npush",  32'(txq.size()), 32'd1);
        check("full_data",   tx_at(0), 32'h07);

        // Reset while waiting for write data discards the command
        clear_logs();
        push_rx(8'h84);
        repeat (4) step_cycle();
        check("rstmid_busy", 32'(o_busy), 32'd1);
        i_rst_n = 1'b0;
        #1;
        check_outputs_zero("rstmid");
        repeat (2) step_cycle();
        i_rst_n = 1'b1;
        repeat (6) step_cycle();
        check("rstmid_notx", 32'(txq.size()), 32'd0);
        check("rstmid_nowr", 32'(wrq.size()), 32'd0);
        push_rx(8'h02);
        wait_tx(1, 20, "rstmid_rd_wait");
        repeat (2) step_cycle();
        check("rstmid_rd",   tx_at(0), 32'hFF);

        // Randomized command batches against the reference model
        rand_full = 1'b1;
        for (int it = 0; it < 30; it++) begin
            clear_logs();
            ncmd = int'($urandom_range(1, 3));
            for (int c = 0; c < ncmd; c++) begin
                kind = int'($urandom_range(0, 9));
                a    = 3'($urandom);
                if (kind < 2) begin
                    cmd = {1'($urandom), 4'($urandom_range(1, 15)), a};
                    rxq.push_back(cmd);
                    expq.push_back(8'h15);
                end else if (kind < 6) begin
                    d = 8'($urandom);
                    rxq.push_back({1'b1, 4'b0000, a});
                    rxq.push_back(d);
                    mregs[a] = d;
                    expq.push_back(8'h06);
                    expwr.push_back({a, d});
                end else begin
                    rxq.push_back({1'b0, 4'b0000, a});
                    expq.push_back(mregs[a]);
                end
            end
            drive();
            wait_tx(expq.size(), 400, "rand_tx_wait");
            check("rand_ntx", 32'(txq.size()), 32'(expq.size()));
            for (int i = 0; i < int'(expq.size()); i++)
                check("rand_resp", tx_at(i), 32'(expq[i]));
            check("rand_nwr", 32'(wrq.size()), 32'(expwr.size()));
            for (int i = 0; i < int'(expwr.size()); i++)
                check("rand_wr", wr_at(i), 32'(expwr[i]));
        end
        rand_full = 1'b0;
        full_ctl  = 1'b0;
        drive();
        repeat (3) step_cycle();
        check("final_idle", 32'(o_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
